// File: rtl/kbd_pkg.sv
// Shared types and constants for the Gigatron keyboard/joystick input scheduler.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } kbd_state_t;

  localparam logic [7:0] IDLE_BYTE = 8'hFF;
  localparam logic [7:0] NO_KEY    = 8'hFF;

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous pending-key FIFO; a pop and push in the same cycle on a full FIFO both succeed.
module kbd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_pop;
  logic             w_push;

  assign empty  = (r_wptr == r_rptr);
  assign full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop  = pop && !empty;
  // A pop frees the slot the coincident push lands in.
  assign w_push = push && (!full || w_pop);
  assign dout   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/kbd_input_sched.sv
// Presents queued key bytes on the Gigatron serial input for HOLD_FRAMES frames, then
// GAP_FRAMES idle frames. Define KBD_JOY_MERGE_EN to show ~joy_buttons while idle.
module kbd_input_sched
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int HOLD_FRAMES = 2,
  parameter int GAP_FRAMES  = 1
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [7:0] key_ascii,
  input  logic [7:0] joy_buttons,
  input  logic       vsync_pulse,
  output logic [7:0] in_byte,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int MAX_FRAMES = (HOLD_FRAMES > GAP_FRAMES) ? HOLD_FRAMES : GAP_FRAMES;
  localparam int CW         = $clog2(MAX_FRAMES) + 1;
  localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_FRAMES - 1);
  localparam logic [CW-1:0] GAP_INIT  = (GAP_FRAMES > 0) ? CW'(GAP_FRAMES - 1) : '0;

  kbd_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    w_head;
  logic [7:0]    w_idle_byte;
  logic          w_empty;
  logic          w_full;
  logic          w_key;
  logic          w_pop;
  logic          w_cnt_zero;
  logic          w_idle_go;

`ifdef KBD_JOY_MERGE_EN
  assign w_idle_byte = ~joy_buttons;
`else
  logic w_unused_joy;
  assign w_unused_joy = ^joy_buttons;
  assign w_idle_byte  = IDLE_BYTE;
`endif

  assign w_key      = key_valid && (key_ascii != NO_KEY);
  assign w_cnt_zero = (r_cnt == '0);
  // Expiring GAP (or HOLD when GAP is disabled) falls straight into the IDLE decision.
  assign w_idle_go  = vsync_pulse &&
                      ((r_state == IDLE) ||
                       (r_state == GAP && w_cnt_zero) ||
                       (r_state == HOLD && w_cnt_zero && GAP_FRAMES == 0));
  assign w_pop      = w_idle_go && !w_empty;
  assign fifo_full  = w_full;

  kbd_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk    (clk_sys),
    .reset_n(reset_n),
    .push   (w_key),
    .pop    (w_pop),
    .din    (key_ascii),
    .dout   (w_head),
    .full   (w_full),
    .empty  (w_empty)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      in_byte  <= IDLE_BYTE;
      overflow <= 1'b0;
    end else begin
      if (w_key && w_full && !w_pop) overflow <= 1'b1;
      if (w_idle_go) begin
        if (!w_empty) begin
          in_byte <= w_head;
          r_cnt   <= HOLD_INIT;
          r_state <= HOLD;
        end else begin
          in_byte <= w_idle_byte;
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      end else if (vsync_pulse) begin
        case (r_state)
          HOLD: begin
            if (w_cnt_zero) begin
              in_byte <= IDLE_BYTE;
              r_cnt   <= GAP_INIT;
              r_state <= GAP;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          GAP:     r_cnt <= r_cnt - 1'b1;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kbd_input_sched.sv
// Self-checking bench for kbd_input_sched against a frame-plan reference model.
module tb_kbd_input_sched;

  localparam int DEPTH = 8;
  localparam int HOLD  = 2;
  localparam int GAP   = 1;
`ifdef KBD_JOY_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic       clk_sys     = 1'b0;
  logic       reset_n     = 1'b0;
  logic       key_valid   = 1'b0;
  logic [7:0] key_ascii   = '0;
  logic [7:0] joy_buttons = '0;
  logic       vsync_pulse = 1'b0;
  logic [7:0] in_byte;
  logic       fifo_full;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  // Model: pending keys, plus the list of bytes still to be shown on upcoming frames.
  logic [7:0] kq[$];
  logic [7:0] plan[$];
  logic [7:0] m_byte = 8'hFF;
  logic       m_ovf  = 1'b0;

  kbd_input_sched #(
    .FIFO_DEPTH (DEPTH),
    .HOLD_FRAMES(HOLD),
    .GAP_FRAMES (GAP)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .key_valid  (key_valid),
    .key_ascii  (key_ascii),
    .joy_buttons(joy_buttons),
    .vsync_pulse(vsync_pulse),
    .in_byte    (in_byte),
    .fifo_full  (fifo_full),
    .overflow   (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] idle_of(input logic [7:0] j);
    return MERGE ? ~j : 8'hFF;
  endfunction

  task automatic step(input logic kv, input logic [7:0] ka, input logic [7:0] joy, input logic vs);
    logic [7:0] k;
    key_valid   = kv;
    key_ascii   = ka;
    joy_buttons = joy;
    vsync_pulse = vs;
    @(posedge clk_sys);
    #1;
    if (!reset_n) begin
      kq.delete();
      plan.delete();
      m_byte = 8'hFF;
      m_ovf  = 1'b0;
    end else begin
      if (vs) begin
        if (plan.size() == 0 && kq.size() > 0) begin
          k = kq.pop_front();
          repeat (HOLD) plan.push_back(k);
          repeat (GAP) plan.push_back(8'hFF);
        end
        if (plan.size() > 0) m_byte = plan.pop_front();
        else                 m_byte = idle_of(joy);
      end
      if (kv && ka != 8'hFF) begin
        if (kq.size() < DEPTH) kq.push_back(ka);
        else                   m_ovf = 1'b1;
      end
    end
    key_valid   = 1'b0;
    vsync_pulse = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    step(1'b0, 8'h00, 8'h00, 1'b0);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (in_byte !== 8'hFF) begin errors++; $display("FAIL reset_in_byte: got %h expected ff", in_byte); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_fifo_full: got %b expected 0", fifo_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_single_key();
    logic [7:0] exp_seq [4];
    apply_reset();
    exp_seq[0] = 8'h61; exp_seq[1] = 8'h61; exp_seq[2] = 8'hFF; exp_seq[3] = idle_of(8'h00);
    step(1'b1, 8'h61, 8'h00, 1'b0);
    for (int f = 0; f < 4; f++) begin
      step(1'b0, 8'h00, 8'h00, 1'b1);
      checks++; if (in_byte !== exp_seq[f]) begin errors++; $display("FAIL single_frame%0d: got %h expected %h", f + 1, in_byte, exp_seq[f]); end
      step(1'b0, 8'h00, 8'h00, 1'b0);
      step(1'b0, 8'h00, 8'h00, 1'b0);
      checks++; if (in_byte !== exp_seq[f]) begin errors++; $display("FAIL single_hold%0d: got %h expected %h", f + 1, in_byte, exp_seq[f]); end
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 8'h30 + 8'(i), 8'h00, 1'b0);
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", fifo_full); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 8'h00, 1'b1);
      checks++; if (in_byte !== 8'h30 + 8'(i)) begin errors++; $display("FAIL ovf_order%0d: got %h expected %h", i, in_byte, 8'h30 + 8'(i)); end
      step(1'b0, 8'h00, 8'h00, 1'b1);
      step(1'b0, 8'h00, 8'h00, 1'b1);
      checks++; if (in_byte !== m_byte) begin errors++; $display("FAIL ovf_gap%0d: got %h expected %h", i, in_byte, m_byte); end
    end
    step(1'b0, 8'h00, 8'h00, 1'b1);
    checks++; if (in_byte !== idle_of(8'h00)) begin errors++; $display("FAIL ovf_drained: got %h expected %h", in_byte, idle_of(8'h00)); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_no_key();
    apply_reset();
    step(1'b1, 8'hFF, 8'h00, 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL nokey_ovf: got %b expected 0", overflow); end
    step(1'b0, 8'h00, 8'h00, 1'b1);
    checks++; if (in_byte !== idle_of(8'h00)) begin errors++; $display("FAIL nokey_empty: got %h expected %h", in_byte, idle_of(8'h00)); end
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h40 + 8'(i), 8'h00, 1'b0);
    step(1'b1, 8'hFF, 8'h00, 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL nokey_full_ovf: got %b expected 0", overflow); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL nokey_full: got %b expected 1", fifo_full); end
  endtask

  // Continues from the full FIFO (0x40..0x47) left by test_no_key.
  task automatic test_full_pop_push();
    logic [7:0] last;
    step(1'b1, 8'h5A, 8'h00, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b expected 0", overflow); end
    checks++; if (in_byte !== 8'h40) begin errors++; $display("FAIL fpp_first: got %h expected 40", in_byte); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fpp_full: got %b expected 1", fifo_full); end
    last = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 8'h00, 1'b1);
      step(1'b0, 8'h00, 8'h00, 1'b1);
      step(1'b0, 8'h00, 8'h00, 1'b1);
      checks++; if (in_byte !== m_byte) begin errors++; $display("FAIL fpp_seq%0d: got %h expected %h", i, in_byte, m_byte); end
      last = in_byte;
    end
    checks++; if (last !== 8'h5A) begin errors++; $display("FAIL fpp_last: got %h expected 5a", last); end
  endtask

  task automatic test_reset_mid_hold();
    apply_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 8'h71 + 8'(i), 8'h00, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b1);
    checks++; if (in_byte !== 8'h71) begin errors++; $display("FAIL rmh_hold: got %h expected 71", in_byte); end
    apply_reset();
    checks++; if (in_byte !== 8'hFF) begin errors++; $display("FAIL rmh_in_byte: got %h expected ff", in_byte); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL rmh_full: got %b expected 0", fifo_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmh_ovf: got %b expected 0", overflow); end
    step(1'b0, 8'h00, 8'h00, 1'b1);
    checks++; if (in_byte !== idle_of(8'h00)) begin errors++; $display("FAIL rmh_empty: got %h expected %h", in_byte, idle_of(8'h00)); end
  endtask

  task automatic test_joy();
    logic [7:0] joys [5];
    logic [7:0] exps [5];
    apply_reset();
    step(1'b0, 8'h00, 8'h01, 1'b1);
    checks++; if (in_byte !== (MERGE ? 8'hFE : 8'hFF)) begin errors++; $display("FAIL joy_idle: got %h expected %h", in_byte, (MERGE ? 8'hFE : 8'hFF)); end
    // Key pushed on a vsync with an empty FIFO waits for the following vsync.
    step(1'b1, 8'h33, 8'h01, 1'b1);
    joys[0] = 8'h01; joys[1] = 8'h0F; joys[2] = 8'h0F; joys[3] = 8'h80; joys[4] = 8'h00;
    exps[0] = 8'h33; exps[1] = 8'h33; exps[2] = 8'hFF; exps[3] = idle_of(8'h80); exps[4] = idle_of(8'h00);
    for (int f = 0; f < 5; f++) begin
      step(1'b0, 8'h00, joys[f], 1'b1);
      checks++; if (in_byte !== exps[f]) begin errors++; $display("FAIL joy_frame%0d: got %h expected %h", f, in_byte, exps[f]); end
    end
  endtask

  task automatic test_random();
    logic       kv;
    logic [7:0] ka;
    logic       vs;
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      if (n == 400) apply_reset();
      kv = ($urandom_range(0, 2) == 0);
      ka = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      vs = ($urandom_range(0, 5) == 0);
      step(kv, ka, 8'($urandom), vs);
      checks++; if (in_byte !== m_byte) begin errors++; $display("FAIL rand_in_byte@%0d: got %h expected %h", n, in_byte, m_byte); end
      checks++; if (fifo_full !== (kq.size() == DEPTH)) begin errors++; $display("FAIL rand_full@%0d: got %b expected %b", n, fifo_full, (kq.size() == DEPTH)); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf@%0d: got %b expected %b", n, overflow, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_overflow();
    test_no_key();
    test_full_pop_push();
    test_reset_mid_hold();
    test_joy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kbd_input_sched.md
KBD_INPUT_SCHED -- requirements
Module: kbd_input_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, giving pending-key capacity (power of two, 2..16).
REQ-002 SHALL have parameter HOLD_FRAMES, default 2, giving the number of vsync frames a key byte is presented.
REQ-003 SHALL have parameter GAP_FRAMES, default 1, giving the number of idle frames after each key.
REQ-004 SHALL have port clk_sys, input, 1, the single system clock.
REQ-005 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port key_valid, input, 1, one-cycle strobe: key_ascii is valid.
REQ-007 SHALL have port key_ascii, input, 8, ASCII code from the keyboard translator; 8'hFF means no key.
REQ-008 SHALL have port joy_buttons, input, 8, active-high gamepad buttons (bit order = Gigatron input bits).
REQ-009 SHALL have port vsync_pulse, input, 1, one-cycle strobe at start of each Gigatron vblank.
REQ-010 SHALL have port in_byte, output, 8, Gigatron serial input byte, active-low, idle 8'hFF.
REQ-011 SHALL have port fifo_full, output, 1, high while FIFO holds FIFO_DEPTH entries.
REQ-012 SHALL have port overflow, output, 1, sticky: a key was dropped.

Function
REQ-013 SHALL push key_ascii into the FIFO on key_valid=1 when key_ascii != 8'hFF and the FIFO is not full.
REQ-014 SHALL ignore key_valid with key_ascii = 8'hFF (no push, no overflow).
REQ-015 SHALL drop the key and set overflow when key_valid arrives with the FIFO full and no pop in the same cycle.
REQ-016 SHALL accept the push when push and pop coincide with the FIFO full (pop first, then push).
REQ-017 SHALL implement states IDLE, HOLD and GAP, advancing only on vsync_pulse cycles.
REQ-018 IDLE + vsync_pulse + FIFO non-empty: pop head, in_byte <= key, frame counter <= HOLD_FRAMES-1, go to HOLD.
REQ-019 IDLE + vsync_pulse + FIFO empty: stay in IDLE; in_byte <= idle value (REQ-027/028).
REQ-020 HOLD + vsync_pulse: counter 0 -> in_byte <= 8'hFF, counter <= GAP_FRAMES-1, go to GAP; otherwise decrement.
REQ-021 GAP + vsync_pulse: counter 0 -> go to IDLE and apply the IDLE rules in the same cycle; otherwise decrement.
REQ-022 in_byte SHALL change only in the cycle after a vsync_pulse (one-cycle registered latency) and hold between pulses.
REQ-023 Joystick state SHALL be ignored in HOLD and GAP.
REQ-024 A key pushed in the same cycle as a vsync_pulse with an empty FIFO SHALL NOT be popped until the next vsync_pulse.
REQ-025 Frame counters SHALL be sized ceil(log2(max(HOLD_FRAMES,GAP_FRAMES)))+1 bits; a GAP_FRAMES value of 0 SHALL skip GAP.

Reset
REQ-026 While reset_n=0 at a clk_sys edge: FIFO emptied, state IDLE, counters 0, in_byte 8'hFF, fifo_full 0, overflow 0; reset mid-HOLD discards the held key.

Configuration
REQ-027 With KBD_JOY_MERGE_EN defined, IDLE idle value SHALL be ~joy_buttons, sampled at the vsync_pulse.
REQ-028 Without KBD_JOY_MERGE_EN, the IDLE idle value SHALL be 8'hFF and joy_buttons SHALL be unused.

Structure
REQ-029 Package kbd_pkg SHALL hold the state enum (IDLE/HOLD/GAP), IDLE_BYTE = 8'hFF and NO_KEY = 8'hFF.
REQ-030 The FIFO SHALL be sub-module kbd_fifo (synchronous, push/pop/full/empty, reset_n clears pointers).

Verification
REQ-031 Push 8'h61 once, then 4 vsync_pulses -> in_byte 8'h61 for frames 1-2, 8'hFF for frame 3, idle value for frame 4.
REQ-032 Push 9 keys 8'h30..8'h38 with no vsync, DEPTH=8 -> fifo_full=1, overflow=1, and 8'h30..8'h37 are emitted in order.
REQ-033 With KBD_JOY_MERGE_EN and joy_buttons=8'h01 and an empty FIFO -> in_byte 8'hFE; press a key -> key presented, joystick ignored in HOLD/GAP.
REQ-034 key_valid with key_ascii=8'hFF -> FIFO is unchanged and overflow stays 0.
REQ-035 Full FIFO, key_valid coincident with a vsync pop -> no overflow, the new key is queued last.
REQ-036 Assert reset_n=0 mid-HOLD -> next cycle in_byte 8'hFF, FIFO empty, overflow 0.
